// File: rtl/riscv_mem_pkg.sv
// Shared types and sizing helpers for the memory-side DRAM responder.
package riscv_mem_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP, RELEASE} dram_state_t;
  typedef enum logic {OP_RD, OP_WR} dram_op_t;

  localparam int DATA_WIDTH_DEF = 128;
  localparam int S_ADDR_DEF     = 10;
  localparam int DEPTH_DEF      = 1024;
  localparam int RD_LAT_DEF     = 4;
  localparam int WR_LAT_DEF     = 4;

  // Counter holds at most LAT-2, so $clog2 of the larger latency always suffices.
  function automatic int lat_w(input int rd_lat, input int wr_lat);
    int m;
    m = (rd_lat > wr_lat) ? rd_lat : wr_lat;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

  localparam int LAT_W = lat_w(RD_LAT_DEF, WR_LAT_DEF);

endpackage

// File: rtl/riscv_dram_ctrl_if.sv
// Cache-to-memory request/response bus seen by the DRAM responder.
interface riscv_dram_ctrl_if #(
  parameter int DATA_WIDTH = 128,
  parameter int S_ADDR     = 10
);
  logic                  i_riscv_dram_wren;
  logic                  i_riscv_dram_rden;
  logic [S_ADDR-1:0]     i_riscv_dram_addr;
  logic [DATA_WIDTH-1:0] i_riscv_dram_data_in;
  logic [DATA_WIDTH-1:0] o_riscv_dram_data_out;
  logic                  o_riscv_dram_mem_ready;

  modport master (
    output i_riscv_dram_wren, i_riscv_dram_rden, i_riscv_dram_addr, i_riscv_dram_data_in,
    input  o_riscv_dram_data_out, o_riscv_dram_mem_ready
  );

  modport slave (
    input  i_riscv_dram_wren, i_riscv_dram_rden, i_riscv_dram_addr, i_riscv_dram_data_in,
    output o_riscv_dram_data_out, o_riscv_dram_mem_ready
  );
endinterface

// File: rtl/riscv_dram_array.sv
// Single-port synchronous line store with registered read data.
module riscv_dram_array #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 1024,
  parameter int AW         = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/riscv_dram_ctrl.sv
// Memory-side responder: latches one line request, answers after a fixed latency,
// then waits for the requester to drop the level request before re-arming.
module riscv_dram_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int S_ADDR     = S_ADDR_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int RD_LATENCY = RD_LAT_DEF,
  parameter int WR_LATENCY = WR_LAT_DEF
) (
  input  logic               i_riscv_dram_clk,
  input  logic               i_riscv_dram_rst,
  riscv_dram_ctrl_if.slave   bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = lat_w(RD_LATENCY, WR_LATENCY);
  localparam logic [S_ADDR:0] DEPTH_L = (S_ADDR+1)'(DEPTH);

  dram_state_t           state;
  dram_op_t              op;
  logic [LW-1:0]         cnt;
  logic [S_ADDR-1:0]     addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  mem_ready;

  logic                  req;
  logic                  in_range;
  logic                  ram_we;
  logic [AW-1:0]         ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign req      = bus.i_riscv_dram_wren | bus.i_riscv_dram_rden;
  assign in_range = {1'b0, addr_q} < DEPTH_L;

  // The RAM reads every cycle; steering it to the bus address while idle means
  // the registered read data is already valid by the time BUSY expires, even at LAT=2.
  assign ram_addr = (state == IDLE) ? bus.i_riscv_dram_addr[AW-1:0] : addr_q[AW-1:0];
  assign ram_we   = i_riscv_dram_rst && (state == BUSY) && (cnt == '0) && req &&
                    (op == OP_WR) && in_range;

  riscv_dram_array #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (i_riscv_dram_clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (data_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge i_riscv_dram_clk) begin
    if (!i_riscv_dram_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_ready <= 1'b0;
      data_out  <= '0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        IDLE: if (req) begin
          op     <= bus.i_riscv_dram_wren ? OP_WR : OP_RD;
          addr_q <= bus.i_riscv_dram_addr;
          data_q <= bus.i_riscv_dram_data_in;
          cnt    <= bus.i_riscv_dram_wren ? LW'(WR_LATENCY - 2) : LW'(RD_LATENCY - 2);
          state  <= BUSY;
        end
        BUSY: begin
          if (!req) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state     <= RESP;
            mem_ready <= 1'b1;
            if (op == OP_RD) data_out <= in_range ? ram_rdata : '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP:    state <= RELEASE;
        RELEASE: if (!req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_riscv_dram_data_out  = data_out;
  assign bus.o_riscv_dram_mem_ready = mem_ready;
endmodule

// File: tb/tb_riscv_dram_ctrl.sv
// Drives a full-depth and a half-depth responder with identical traffic and
// compares both against a line-level model of the memory.
module tb_riscv_dram_ctrl;
  localparam int DW  = 128;
  localparam int SA  = 10;
  localparam int RDL = 4;
  localparam int WRL = 4;
  localparam int DEPTH_B = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_dram_ctrl_if #(.DATA_WIDTH(DW), .S_ADDR(SA)) bus_a ();
  riscv_dram_ctrl_if #(.DATA_WIDTH(DW), .S_ADDR(SA)) bus_b ();

  assign bus_b.i_riscv_dram_wren    = bus_a.i_riscv_dram_wren;
  assign bus_b.i_riscv_dram_rden    = bus_a.i_riscv_dram_rden;
  assign bus_b.i_riscv_dram_addr    = bus_a.i_riscv_dram_addr;
  assign bus_b.i_riscv_dram_data_in = bus_a.i_riscv_dram_data_in;

  riscv_dram_ctrl #(.DATA_WIDTH(DW), .S_ADDR(SA), .DEPTH(1024),
                    .RD_LATENCY(RDL), .WR_LATENCY(WRL)) dut_a (
    .i_riscv_dram_clk (clk),
    .i_riscv_dram_rst (rst_n),
    .bus              (bus_a)
  );

  riscv_dram_ctrl #(.DATA_WIDTH(DW), .S_ADDR(SA), .DEPTH(DEPTH_B),
                    .RD_LATENCY(RDL), .WR_LATENCY(WRL)) dut_b (
    .i_riscv_dram_clk (clk),
    .i_riscv_dram_rst (rst_n),
    .bus              (bus_b)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] mem_a [int];
  logic [DW-1:0] mem_b [int];
  logic [DW-1:0] exp_a = '0;
  logic [DW-1:0] exp_b = '0;
  logic [SA-1:0] pool [12] = '{10'h005, 10'h010, 10'h020, 10'h030, 10'h3FF, 10'h1FF,
                               10'h200, 10'h2A5, 10'h000, 10'h0C3, 10'h155, 10'h301};

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Line-level effect of one completed request on each memory image.
  task automatic model_commit(input logic wr, input logic [SA-1:0] a, input logic [DW-1:0] d);
    if (wr) begin
      mem_a[int'(a)] = d;
      if (int'(a) < DEPTH_B) mem_b[int'(a)] = d;
    end else begin
      exp_a = mem_a[int'(a)];
      exp_b = (int'(a) < DEPTH_B) ? mem_b[int'(a)] : '0;
    end
  endtask

  // Full transaction: request held until mem_ready plus 'extra' cycles, with the
  // address/data scrambled after accept to prove the latched copy is used.
  task automatic xact(input logic wr, input logic rd, input logic [SA-1:0] a,
                      input logic [DW-1:0] d, input int extra);
    int lat, lat_a, lat_b, np_a, np_b;
    lat = wr ? WRL : RDL;
    lat_a = 0; lat_b = 0; np_a = 0; np_b = 0;
    bus_a.i_riscv_dram_wren    = wr;
    bus_a.i_riscv_dram_rden    = rd;
    bus_a.i_riscv_dram_addr    = a;
    bus_a.i_riscv_dram_data_in = d;
    for (int k = 1; k <= lat + 1 + extra; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus_a.i_riscv_dram_addr    = a ^ 10'h155;
        bus_a.i_riscv_dram_data_in = ~d;
      end
      if (bus_a.o_riscv_dram_mem_ready) begin np_a++; if (lat_a == 0) lat_a = k; end
      if (bus_b.o_riscv_dram_mem_ready) begin np_b++; if (lat_b == 0) lat_b = k; end
    end
    bus_a.i_riscv_dram_wren = 1'b0;
    bus_a.i_riscv_dram_rden = 1'b0;
    @(negedge clk);
    if (bus_a.o_riscv_dram_mem_ready) np_a++;
    if (bus_b.o_riscv_dram_mem_ready) np_b++;
    model_commit(wr, a, d);
    check("lat_a", DW'(lat_a), DW'(lat));
    check("lat_b", DW'(lat_b), DW'(lat));
    check("pulses_a", DW'(np_a), DW'(1));
    check("pulses_b", DW'(np_b), DW'(1));
    check("dout_a", bus_a.o_riscv_dram_data_out, exp_a);
    check("dout_b", bus_b.o_riscv_dram_data_out, exp_b);
  endtask

  // Request withdrawn two cycles after accept: nothing may complete or change.
  task automatic abort_req(input logic wr, input logic rd, input logic [SA-1:0] a,
                           input logic [DW-1:0] d);
    int np;
    np = 0;
    bus_a.i_riscv_dram_wren    = wr;
    bus_a.i_riscv_dram_rden    = rd;
    bus_a.i_riscv_dram_addr    = a;
    bus_a.i_riscv_dram_data_in = d;
    repeat (2) @(negedge clk);
    bus_a.i_riscv_dram_wren = 1'b0;
    bus_a.i_riscv_dram_rden = 1'b0;
    for (int k = 0; k < RDL + WRL; k++) begin
      @(negedge clk);
      if (bus_a.o_riscv_dram_mem_ready || bus_b.o_riscv_dram_mem_ready) np++;
    end
    check("abort_pulses", DW'(np), DW'(0));
    check("abort_dout_a", bus_a.o_riscv_dram_data_out, exp_a);
    check("abort_dout_b", bus_b.o_riscv_dram_data_out, exp_b);
  endtask

  initial begin
    bus_a.i_riscv_dram_wren    = 1'b0;
    bus_a.i_riscv_dram_rden    = 1'b0;
    bus_a.i_riscv_dram_addr    = '0;
    bus_a.i_riscv_dram_data_in = '0;
    repeat (3) @(negedge clk);
    check("rst_rdy_a", DW'(bus_a.o_riscv_dram_mem_ready), '0);
    check("rst_rdy_b", DW'(bus_b.o_riscv_dram_mem_ready), '0);
    check("rst_dout_a", bus_a.o_riscv_dram_data_out, '0);
    check("rst_dout_b", bus_b.o_riscv_dram_data_out, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read back a known line; the write must leave data_out at zero.
    xact(1'b1, 1'b0, 10'h005, {4{32'hDEADBEEF}}, 0);
    xact(1'b0, 1'b1, 10'h005, '0, 0);

    foreach (pool[i]) if (pool[i] != 10'h005) xact(1'b1, 1'b0, pool[i], rnd_line(), 0);

    // Held request across several cycles after completion.
    xact(1'b0, 1'b1, 10'h005, '0, 3);
    xact(1'b0, 1'b1, 10'h3FF, '0, 0);

    // Simultaneous write and read: the write wins.
    xact(1'b1, 1'b1, 10'h010, DW'(1), 0);
    xact(1'b0, 1'b1, 10'h010, '0, 0);

    // Dropped read and dropped write leave everything intact.
    abort_req(1'b0, 1'b1, 10'h020, '0);
    abort_req(1'b1, 1'b0, 10'h020, rnd_line());
    xact(1'b0, 1'b1, 10'h020, '0, 0);

    // Top line: present in the full array, out of range in the half-depth one.
    xact(1'b1, 1'b0, 10'h3FF, rnd_line(), 1);
    xact(1'b0, 1'b1, 10'h3FF, '0, 0);

    // Reset while a write is in flight.
    bus_a.i_riscv_dram_wren    = 1'b1;
    bus_a.i_riscv_dram_addr    = 10'h030;
    bus_a.i_riscv_dram_data_in = rnd_line();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_rdy", DW'(bus_a.o_riscv_dram_mem_ready), '0);
    check("midrst_dout_a", bus_a.o_riscv_dram_data_out, '0);
    check("midrst_dout_b", bus_b.o_riscv_dram_data_out, '0);
    exp_a = '0;
    exp_b = '0;
    bus_a.i_riscv_dram_wren = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    xact(1'b0, 1'b1, 10'h030, '0, 0);

    for (int n = 0; n < 40; n++) begin
      int sel, ex;
      logic [SA-1:0] a;
      sel = $urandom_range(0, 5);
      ex  = $urandom_range(0, 3);
      a   = pool[$urandom_range(0, 11)];
      case (sel)
        0:       abort_req(1'($urandom_range(0, 1)), 1'b1, a, rnd_line());
        1, 2:    xact(1'b1, 1'b0, a, rnd_line(), ex);
        5:       xact(1'b1, 1'b1, a, rnd_line(), ex);
        default: xact(1'b0, 1'b1, a, '0, ex);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
